// File: rtl/led_flash_pkg.sv
// Shared types and widths for the LED flash driver and its per-LED channels.
package led_flash_pkg;
    localparam int NUM_LEDS    = 8;
    localparam int FLASH_CNT_W = 8;
    localparam int PWM_W       = 4;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        FLASH = 2'd1,
        DIM   = 2'd2
    } ch_state_e;
endpackage

// File: rtl/led_flash_if.sv
// LED command/drive bundle between the PIO side (master) and the flash driver (slave).
interface led_flash_if;
    import led_flash_pkg::*;

    logic [NUM_LEDS-1:0] led_cmd;
    logic [NUM_LEDS-1:0] ledr;
    logic                busy;

    modport master (output led_cmd, input ledr, input busy);
    modport slave  (input led_cmd, output ledr, output busy);
endinterface

// File: rtl/led_flash_channel.sv
// One LED: OFF/FLASH/DIM state machine with a tick-counted flash and PWM dimming.
module led_flash_channel
    import led_flash_pkg::*;
#(
    parameter int FLASH_TICKS = 100,
    parameter int DIM_LEVEL   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rise,
    input  logic             fall,
    input  logic             tick,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             drive,
    output logic             in_flash
);
    localparam logic [FLASH_CNT_W-1:0] FT_LOAD = FLASH_CNT_W'(FLASH_TICKS);
    // One extra bit so DIM_LEVEL=16 compares as "always below"
    localparam logic [PWM_W:0]         LVL     = (PWM_W+1)'(DIM_LEVEL);

    ch_state_e              r_state, w_state_nxt;
    logic [FLASH_CNT_W-1:0] r_flash_cnt, w_cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= OFF;
            r_flash_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flash_cnt <= w_cnt_nxt;
        end
    end

    // Edges win over the tick so a fresh load is never decremented in its first cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_flash_cnt;
        if (fall) begin
            w_state_nxt = OFF;
            w_cnt_nxt   = '0;
        end else if (rise) begin
            w_state_nxt = FLASH;
            w_cnt_nxt   = FT_LOAD;
        end else if (r_state == FLASH && tick) begin
            if (r_flash_cnt == FLASH_CNT_W'(1)) begin
                w_state_nxt = DIM;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_flash_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        drive = 1'b0;
        case (r_state)
            FLASH:   drive = 1'b1;
            DIM:     drive = ({1'b0, pwm_cnt} < LVL);
            default: drive = 1'b0;
        endcase
    end

    assign in_flash = (r_state == FLASH);
endmodule

// File: rtl/led_flash_driver.sv
// Eight-LED flash driver: shared prescaler/PWM, edge detect, registered LED drive and busy.
module led_flash_driver
    import led_flash_pkg::*;
#(
    parameter int PRESCALE    = 50000,
    parameter int FLASH_TICKS = 100,
    parameter int DIM_LEVEL   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    led_flash_if.slave  bus
);
    localparam int PRE_W = $clog2(PRESCALE);

    logic [NUM_LEDS-1:0] r_cmd_q;
    logic [PRE_W-1:0]    r_pre;
    logic [PWM_W-1:0]    r_pwm_cnt;
    logic                w_tick;
    logic [NUM_LEDS-1:0] w_rise, w_fall, w_drive, w_in_flash;

    assign w_tick = (r_pre == PRE_W'(PRESCALE - 1));
    assign w_rise = bus.led_cmd & ~r_cmd_q;
    assign w_fall = ~bus.led_cmd & r_cmd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_q   <= '0;
            r_pre     <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_cmd_q   <= bus.led_cmd;
            r_pre     <= w_tick ? '0 : r_pre + 1'b1;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_flash_channel #(
            .FLASH_TICKS (FLASH_TICKS),
            .DIM_LEVEL   (DIM_LEVEL)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .rise     (w_rise[g]),
            .fall     (w_fall[g]),
            .tick     (w_tick),
            .pwm_cnt  (r_pwm_cnt),
            .drive    (w_drive[g]),
            .in_flash (w_in_flash[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ledr <= '0;
            bus.busy <= 1'b0;
        end else begin
            bus.ledr <= w_drive;
            bus.busy <= |w_in_flash;
        end
    end
endmodule

// File: tb/tb_led_flash_driver.sv
// Random + directed bench: three drivers (dim 4/16/0) share one command against a tick-count model.
module tb_led_flash_driver;
    localparam int P  = 4;
    localparam int FT = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] cmd = 8'h00;

    always #5 clk = ~clk;

    led_flash_if if4 ();
    led_flash_if if16 ();
    led_flash_if if0 ();
    assign if4.led_cmd  = cmd;
    assign if16.led_cmd = cmd;
    assign if0.led_cmd  = cmd;

    led_flash_driver #(.PRESCALE(P), .FLASH_TICKS(FT), .DIM_LEVEL(4))
        u_dut4 (.clk(clk), .reset_n(reset_n), .bus(if4.slave));
    led_flash_driver #(.PRESCALE(P), .FLASH_TICKS(FT), .DIM_LEVEL(16))
        u_dut16 (.clk(clk), .reset_n(reset_n), .bus(if16.slave));
    led_flash_driver #(.PRESCALE(P), .FLASH_TICKS(FT), .DIM_LEVEL(0))
        u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: per LED, ticks of flash left (-1 off, 0 dimmed); cyc = active clocks since release
    int         rem [8];
    logic [7:0] q;
    int         cyc;
    logic [7:0] e4, e16, e0;
    logic       eb;

    function automatic logic lit(input int r, input int pwm, input int lvl);
        if (r < 0) return 1'b0;
        if (r > 0) return 1'b1;
        return (pwm < lvl);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) rem[i] = -1;
        q = 8'h00; cyc = 0;
        e4 = 8'h00; e16 = 8'h00; e0 = 8'h00; eb = 1'b0;
    endtask

    // Outcome of the coming clock edge given the command now on the input
    task automatic m_step();
        bit tick;
        int pwm;
        tick = (cyc % P) == (P - 1);
        pwm  = cyc % 16;
        eb   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e4[i]  = lit(rem[i], pwm, 4);
            e16[i] = lit(rem[i], pwm, 16);
            e0[i]  = lit(rem[i], pwm, 0);
            if (rem[i] > 0) eb = 1'b1;
            if (!cmd[i] && q[i])                 rem[i] = -1;
            else if (cmd[i] && !q[i])            rem[i] = FT;
            else if (rem[i] > 0 && tick)         rem[i] = rem[i] - 1;
        end
        q = cmd;
        cyc++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ledr4"},  32'(if4.ledr),  32'(e4));
        chk({tag, ".ledr16"}, 32'(if16.ledr), 32'(e16));
        chk({tag, ".ledr0"},  32'(if0.ledr),  32'(e0));
        chk({tag, ".busy"},   32'({if0.busy, if16.busy, if4.busy}), 32'({3{eb}}));
    endtask

    task automatic step(input logic [7:0] c, input string tag);
        @(negedge clk);
        check_all(tag);
        cmd = c;
        if (reset_n) m_step();
    endtask

    task automatic hold(input logic [7:0] c, input int n, input string tag);
        repeat (n) step(c, tag);
    endtask

    task automatic do_reset(input int n, input string tag);
        @(negedge clk);
        check_all(tag);
        reset_n = 1'b0;
        #1;
        chk({tag, ".ledr_async"}, 32'({if0.ledr, if16.ledr, if4.ledr}), 32'h0);
        chk({tag, ".busy_async"}, 32'({if0.busy, if16.busy, if4.busy}), 32'h0);
        m_reset();
        repeat (n) begin
            @(negedge clk);
            check_all({tag, "_hold"});
        end
        reset_n = 1'b1;
        m_step();
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        chk("reset.ledr", 32'({if0.ledr, if16.ledr, if4.ledr}), 32'h0);
        chk("reset.busy", 32'({if0.busy, if16.busy, if4.busy}), 32'h0);
        reset_n = 1'b1;
        m_step();

        // flash then dim on bit 0
        hold(8'h00, 3, "idle");
        hold(8'h01, 40, "flash_dim");
        // retrigger out of dim with a one-clock low pulse
        hold(8'h00, 1, "retrig_lo");
        hold(8'h01, 30, "retrig");
        // drop during flash
        hold(8'h00, 2, "pre_drop");
        hold(8'h01, 5, "drop_flash");
        hold(8'h00, 20, "drop");

        // swap halves on a clock that carries a tick
        hold(8'h0F, 30, "lo_nib");
        while ((cyc % P) != (P - 1)) step(8'h0F, "align");
        step(8'hF0, "simul");
        hold(8'hF0, 30, "hi_nib");

        // reset mid-flash with all bits held high through it
        hold(8'h00, 2, "pre_ff");
        hold(8'hFF, 6, "ff_flash");
        do_reset(3, "rst_mid");
        hold(8'hFF, 30, "post_rst");

        for (int k = 0; k < 2500; k++) begin
            int r;
            logic [7:0] nc;
            r  = $urandom_range(0, 199);
            nc = cmd;
            if (r < 20) nc = cmd ^ 8'($urandom_range(1, 255));
            if (r == 199) do_reset($urandom_range(1, 3), "rnd_rst");
            else step(nc, "rnd");
        end
        hold(cmd, 2, "tail");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
